// File: rtl/spi_flash_boot_loader.sv
// Boot loader: streams memsize bytes from SPI flash (one READ burst) into RAM over a
// Wishbone write port, holding the CPU in reset until the copy completes.
module spi_flash_boot_loader #(
  parameter int unsigned memsize      = 2048,
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter int unsigned SCK_DIV      = 2,
  localparam int unsigned AW          = (memsize > 4) ? $clog2(memsize / 4) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flash_miso,
  output logic          o_flash_sck,
  output logic          o_flash_ss,
  output logic          o_flash_mosi,
  output logic [AW-1:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic          i_wb_ack,
  output logic          o_cpu_rst,
  output logic          o_done
);

  localparam int unsigned NWORDS = memsize / 4;
  localparam int unsigned DIVW   = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StWrite, StDone} state_t;

  state_t        r_state, w_state_next;
  logic [DIVW-1:0] r_div;
  logic          r_sck, r_ss, r_mosi, r_cyc, r_cpu_rst, r_done;
  logic [5:0]    r_bit;
  logic [31:0]   r_tx, r_rx, r_dat;
  logic [AW-1:0] r_adr;
  logic [AW:0]   r_word;

  logic          w_spi_active, w_div_wrap, w_rise, w_fall, w_field_end, w_ack, w_last_word;
  logic [5:0]    w_field_len;

  assign w_spi_active = (r_state == StCmd) || (r_state == StAddr) || (r_state == StData);
  assign w_div_wrap   = w_spi_active && (r_div == DIVW'(SCK_DIV - 1));
  assign w_rise       = w_div_wrap && !r_sck;
  assign w_fall       = w_div_wrap && r_sck;
  assign w_ack        = r_cyc && i_wb_ack;
  assign w_last_word  = (r_word == (AW + 1)'(NWORDS - 1));

  always_comb begin
    w_field_len = 6'd32;
    case (r_state)
      StCmd:   w_field_len = 6'd8;
      StAddr:  w_field_len = 6'd24;
      default: w_field_len = 6'd32;
    endcase
  end

  // Fields end on the falling SCK after their last rising edge, so SCK is low on exit
  assign w_field_end = w_fall && (r_bit == w_field_len);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  w_state_next = StCmd;
      StCmd:   if (w_field_end) w_state_next = StAddr;
      StAddr:  if (w_field_end) w_state_next = StData;
      StData:  if (w_field_end) w_state_next = StWrite;
      StWrite: if (w_ack) w_state_next = w_last_word ? StDone : StData;
      default: w_state_next = StDone;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_div     <= '0;
      r_sck     <= 1'b0;
      r_ss      <= 1'b1;
      r_mosi    <= 1'b0;
      r_cyc     <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_dat     <= '0;
      r_adr     <= '0;
      r_word    <= '0;
    end else begin
      if (!w_spi_active || w_div_wrap) r_div <= '0;
      else                             r_div <= r_div + 1'b1;
      if (w_div_wrap) r_sck <= !r_sck;

      if (w_field_end) r_bit <= '0;
      else if (w_rise) r_bit <= r_bit + 6'd1;

      if (w_rise && (r_state == StData)) r_rx <= {r_rx[30:0], i_flash_miso};

      // Command and address share one shifter; the MSB of 0x03 is 0
      if (r_state == StIdle) begin
        r_ss   <= 1'b0;
        r_tx   <= {8'h03, FLASH_OFFSET};
        r_mosi <= 1'b0;
      end else if (w_fall) begin
        r_tx   <= {r_tx[30:0], 1'b0};
        r_mosi <= r_tx[30];
      end

      if ((r_state == StData) && w_field_end) begin
        r_cyc <= 1'b1;
        r_adr <= r_word[AW-1:0];
        r_dat <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
      end

      if (w_ack) begin
        r_cyc  <= 1'b0;
        r_word <= r_word + 1'b1;
        if (w_last_word) begin
          r_ss      <= 1'b1;
          r_cpu_rst <= 1'b0;
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign o_flash_sck  = r_sck;
  assign o_flash_ss   = r_ss;
  assign o_flash_mosi = r_mosi;
  assign o_wb_adr     = r_adr;
  assign o_wb_dat     = r_dat;
  assign o_wb_sel     = {4{r_cyc}};
  assign o_wb_we      = r_cyc;
  assign o_wb_cyc     = r_cyc;
  assign o_cpu_rst    = r_cpu_rst;
  assign o_done       = r_done;

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Bench for spi_flash_boot_loader: two instances (SCK_DIV 4 / offset 0 and SCK_DIV 1 /
// offset 0x100000) driven by a behavioural flash and a RAM with programmable wait states.
module tb_spi_flash_boot_loader;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       rst [2], miso [2], sck [2], ss [2], mosi [2], we [2], cyc [2], ack [2];
  logic       cpu_rst [2], done [2], mbit [2], tog [2], ackr [2], force_ack [2];
  logic [1:0] adr [2];
  logic [31:0] dat [2];
  logic [3:0] sel [2];

  assign miso[0] = mbit[0] ^ tog[0];
  assign miso[1] = mbit[1] ^ tog[1];
  assign ack[0]  = ackr[0] | force_ack[0];
  assign ack[1]  = ackr[1] | force_ack[1];

  spi_flash_boot_loader #(.memsize(16), .FLASH_OFFSET(24'h000000), .SCK_DIV(4)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_flash_miso(miso[0]), .o_flash_sck(sck[0]),
    .o_flash_ss(ss[0]), .o_flash_mosi(mosi[0]), .o_wb_adr(adr[0]), .o_wb_dat(dat[0]),
    .o_wb_sel(sel[0]), .o_wb_we(we[0]), .o_wb_cyc(cyc[0]), .i_wb_ack(ack[0]),
    .o_cpu_rst(cpu_rst[0]), .o_done(done[0]));

  spi_flash_boot_loader #(.memsize(16), .FLASH_OFFSET(24'h100000), .SCK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_flash_miso(miso[1]), .o_flash_sck(sck[1]),
    .o_flash_ss(ss[1]), .o_flash_mosi(mosi[1]), .o_wb_adr(adr[1]), .o_wb_dat(dat[1]),
    .o_wb_sel(sel[1]), .o_wb_we(we[1]), .o_wb_cyc(cyc[1]), .i_wb_ack(ack[1]),
    .o_cpu_rst(cpu_rst[1]), .o_done(done[1]));

  int          tick;
  int          bcnt [2], cnt [2], wcount [2], cyc_cycles [2], viol [2], nrise [2], t_ss [2];
  int          rise_t [2][2];
  int          clr_gen [2], seen_gen [2], dly_word [2], dly_wait [2];
  logic [31:0] hdr [2];
  logic [1:0]  wadr [2][8];
  logic [31:0] wdat [2][8];
  logic        sck_p [2], ss_p [2], cyc_p [2], done_p [2];
  logic [1:0]  adr_p [2];
  logic [31:0] dat_p [2];
  logic [39:0] out_p [2];

  function automatic logic [39:0] outs(int g);
    return {ss[g], sck[g], mosi[g], cyc[g], adr[g], dat[g], cpu_rst[g], done[g]};
  endfunction

  // Flash model, RAM acknowledger and protocol monitor, all sampled on the falling clock
  initial begin
    int o, need;
    logic [23:0] fa;
    logic [7:0]  fb;
    tick = 0;
    for (int g = 0; g < 2; g++) begin
      bcnt[g] = 0; cnt[g] = 0; wcount[g] = 0; cyc_cycles[g] = 0; viol[g] = 0; nrise[g] = 0;
      t_ss[g] = 0; seen_gen[g] = 0; hdr[g] = '0; mbit[g] = 1'b0; ackr[g] = 1'b0;
      sck_p[g] = 1'b0; ss_p[g] = 1'b1; cyc_p[g] = 1'b0; done_p[g] = 1'b0;
      adr_p[g] = '0; dat_p[g] = '0; out_p[g] = '0;
      rise_t[g][0] = 0; rise_t[g][1] = 0;
    end
    forever begin
      @(negedge clk);
      tick++;
      for (int g = 0; g < 2; g++) begin
        if (clr_gen[g] != seen_gen[g]) begin
          seen_gen[g] = clr_gen[g];
          wcount[g] = 0; cyc_cycles[g] = 0; viol[g] = 0; nrise[g] = 0; hdr[g] = '0; t_ss[g] = 0;
        end
        if (ss[g]) begin
          bcnt[g] = 0;
          mbit[g] = 1'b0;
        end else begin
          if (ss_p[g]) begin
            t_ss[g] = tick; nrise[g] = 0; hdr[g] = '0;
          end
          if (sck[g] && !sck_p[g]) begin
            if (bcnt[g] < 32) hdr[g] = {hdr[g][30:0], mosi[g]};
            if (nrise[g] < 2) rise_t[g][nrise[g]] = tick;
            nrise[g]++;
            bcnt[g]++;
          end else if (!sck[g] && sck_p[g] && bcnt[g] >= 32) begin
            o = bcnt[g] - 32;
            fa = hdr[g][23:0] + 24'(o / 8);
            fb = fa[7:0] + fa[23:16];
            mbit[g] = fb[3'(7 - (o % 8))];
          end
        end
        if (cyc[g]) begin
          cyc_cycles[g]++;
          if (sel[g] != 4'hF || !we[g] || sck[g] || ss[g]) viol[g]++;
          if (cyc_p[g] && (adr[g] != adr_p[g] || dat[g] != dat_p[g])) viol[g]++;
          need = (int'(adr[g]) == dly_word[g]) ? dly_wait[g] : 0;
          if (cnt[g] < need) begin
            cnt[g]++;
            ackr[g] = 1'b0;
          end else begin
            ackr[g] = 1'b1;
            if (wcount[g] < 8) begin
              wadr[g][wcount[g]] = adr[g];
              wdat[g][wcount[g]] = dat[g];
            end
            wcount[g]++;
          end
        end else begin
          cnt[g] = 0;
          ackr[g] = 1'b0;
          if (we[g] || sel[g] != 4'h0) viol[g]++;
        end
        if (done[g] && done_p[g] && outs(g) != out_p[g]) viol[g]++;
        sck_p[g] = sck[g]; ss_p[g] = ss[g]; cyc_p[g] = cyc[g]; done_p[g] = done[g];
        adr_p[g] = adr[g]; dat_p[g] = dat[g]; out_p[g] = outs(g);
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_pass(int g);
    @(negedge clk);
    rst[g] = 1'b0;
    clr_gen[g]++;
    repeat (2) @(negedge clk);
    rst[g] = 1'b1;
  endtask

  task automatic wait_done(int g, output int cycles);
    cycles = 0;
    while (cycles < 20000) begin
      @(posedge clk);
      cycles++;
      #1;
      if (done[g]) break;
    end
    check($sformatf("done_reached_g%0d", g), 64'(done[g]), 64'd1);
  endtask

  typedef struct {
    int               inst;
    int               dword;
    int               dwait;
    logic [31:0]      hdr;
    logic [3:0][31:0] w;
  } vec_t;

  vec_t vecs [4];

  localparam logic [3:0][31:0] WordsOff0 = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
  localparam logic [3:0][31:0] WordsOff1 = {32'h1F1E1D1C, 32'h1B1A1918, 32'h17161514, 32'h13121110};

  initial begin
    int cyc_n, d, g, n, wc;
    logic [39:0] snap;
    vec_t v;

    vecs[0] = '{inst: 0, dword: -1, dwait: 0, hdr: 32'h03000000, w: WordsOff0};
    vecs[1] = '{inst: 1, dword: -1, dwait: 0, hdr: 32'h03100000, w: WordsOff1};
    vecs[2] = '{inst: 0, dword: 1,  dwait: 5, hdr: 32'h03000000, w: WordsOff0};
    vecs[3] = '{inst: 1, dword: 3,  dwait: 3, hdr: 32'h03100000, w: WordsOff1};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; tog[i] = 1'b0; force_ack[i] = 1'b0; clr_gen[i] = 0;
      dly_word[i] = -1; dly_wait[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_outputs_g%0d", i), 64'(outs(i)), {24'd0, 4'b1000, 34'd0, 2'b10});

    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      g = v.inst;
      d = (g == 0) ? 4 : 1;
      dly_word[g] = v.dword;
      dly_wait[g] = v.dwait;
      start_pass(g);
      wait_done(g, cyc_n);
      check($sformatf("v%0d_mosi_header", i), 64'(hdr[g]), 64'(v.hdr));
      check($sformatf("v%0d_write_count", i), 64'(wcount[g]), 64'd4);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("v%0d_adr%0d", i, k), 64'(wadr[g][k]), 64'(k));
        check($sformatf("v%0d_dat%0d", i, k), 64'(wdat[g][k]), 64'(v.w[k]));
      end
      check($sformatf("v%0d_done_outputs", i), 64'(outs(g)),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 2'd3, v.w[3], 1'b0, 1'b1}));
      check($sformatf("v%0d_latency_%0d_in_range", i, cyc_n),
            64'(cyc_n >= 320 * d && cyc_n <= 320 * d + 16 + v.dwait), 64'd1);
      check($sformatf("v%0d_cyc_cycles", i), 64'(cyc_cycles[g]), 64'(4 + v.dwait));
      check($sformatf("v%0d_protocol_violations", i), 64'(viol[g]), 64'd0);
      check($sformatf("v%0d_sck_period", i), 64'(rise_t[g][1] - rise_t[g][0]), 64'(2 * d));
      check($sformatf("v%0d_mosi_lead", i), 64'(rise_t[g][0] - t_ss[g] >= d), 64'd1);
    end

    // Quiet DONE: miso and ack activity must not disturb anything
    snap = outs(0);
    wc = wcount[0];
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tog[0] = ~tog[0];
      force_ack[0] = ~force_ack[0];
    end
    @(negedge clk);
    tog[0] = 1'b0;
    force_ack[0] = 1'b0;
    @(negedge clk);
    check("done_outputs_hold", 64'(outs(0)), 64'(snap));
    check("done_no_writes", 64'(wcount[0]), 64'(wc));
    check("done_no_violations", 64'(viol[0]), 64'd0);

    // Reset in the middle of word 2, then a full restart
    dly_word[0] = -1;
    dly_wait[0] = 0;
    start_pass(0);
    n = 0;
    while (wcount[0] < 2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_word2", 64'(wcount[0]), 64'd2);
    repeat (100) @(negedge clk);
    check("abort_ss_low_before", 64'({ss[0], cyc[0], wcount[0] == 2}), 64'b001);
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ss_sck_cpu_rst", 64'({ss[0], sck[0], cpu_rst[0], done[0]}), 64'b1010);
    start_pass(0);
    wait_done(0, cyc_n);
    check("restart_mosi_header", 64'(hdr[0]), 64'h03000000);
    check("restart_write_count", 64'(wcount[0]), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("restart_adr%0d", k), 64'(wadr[0][k]), 64'(k));
      check($sformatf("restart_dat%0d", k), 64'(wdat[0][k]), 64'(WordsOff0[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
